// File: rtl/hc_sr04_emulator.sv
// HC-SR04 responder model: trigger pulse in, echo pulse out whose width encodes range_cm.
// Optional macro HC_SR04_EMU_TIMEOUT_EN: out-of-range targets give a DELAY_TIMEOUT_US echo instead of clamping.
module hc_sr04_emulator #(
    parameter int unsigned RANGE_WIDTH      = 16,
    parameter int unsigned DELAY_CLK_1US    = 50,
    parameter int unsigned DELAY_1US_1SM    = 58,
    parameter int unsigned DELAY_TRIGGER_US = 10,
    parameter int unsigned DELAY_BURST_US   = 450,
    parameter int unsigned DELAY_TIMEOUT_US = 38000,
    parameter int unsigned MAX_RANGE_CM     = 400,
    parameter int unsigned DELAY_HOLDOFF_US = 10000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trigger,
    input  logic [RANGE_WIDTH-1:0] range_cm,
    output logic                   echo,
    output logic                   busy,
    output logic                   trig_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_BURST,
        S_ECHO,
        S_HOLD
    } state_t;

    localparam int unsigned PW = (DELAY_CLK_1US > 1) ? $clog2(DELAY_CLK_1US) : 1;
    localparam logic [PW-1:0]          PRESC_LAST = PW'(DELAY_CLK_1US - 1);
    localparam logic [24:0]            TRIG_MIN   = 25'(DELAY_TRIGGER_US);
    localparam logic [23:0]            BURST_LAST = 24'(DELAY_BURST_US - 1);
    localparam logic [23:0]            HOLD_LAST  = 24'(DELAY_HOLDOFF_US - 1);
    localparam logic [23:0]            US_PER_CM  = 24'(DELAY_1US_1SM);
    localparam logic [RANGE_WIDTH-1:0] MAX_R      = RANGE_WIDTH'(MAX_RANGE_CM);
`ifdef HC_SR04_EMU_TIMEOUT_EN
    localparam logic [23:0]            TIMEOUT_W  = 24'(DELAY_TIMEOUT_US);
`endif

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q, hist_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [23:0]     us_q, us_d;
    logic [23:0]     width_q, width_d;
    logic            echo_q, echo_d;
    logic            busy_q, busy_d;
    logic            trig_err_q, trig_err_d;

    logic            trig_rise, trig_fall, tick, out_of_range;
    logic [24:0]     us_eff;
    logic [23:0]     width_calc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            presc_q    <= '0;
            us_q       <= '0;
            width_q    <= '0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            trig_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= trigger;
            sync2_q    <= sync1_q;
            hist_q     <= sync2_q;
            presc_q    <= presc_d;
            us_q       <= us_d;
            width_q    <= width_d;
            echo_q     <= echo_d;
            busy_q     <= busy_d;
            trig_err_q <= trig_err_d;
        end
    end

    // Echo width is fixed from range_cm at the moment the trigger is accepted.
    always_comb begin
        out_of_range = (range_cm == '0) || (range_cm > MAX_R);
`ifdef HC_SR04_EMU_TIMEOUT_EN
        width_calc = out_of_range ? TIMEOUT_W : 24'(range_cm) * US_PER_CM;
`else
        if (range_cm == '0)
            width_calc = US_PER_CM;
        else if (range_cm > MAX_R)
            width_calc = 24'(MAX_R) * US_PER_CM;
        else
            width_calc = 24'(range_cm) * US_PER_CM;
`endif
    end

    always_comb begin
        trig_rise  = sync2_q & ~hist_q;
        trig_fall  = ~sync2_q & hist_q;
        tick       = (presc_q == PRESC_LAST);
        // Count the tick landing in the fall cycle so an exact-length pulse is accepted.
        us_eff     = {1'b0, us_q} + {24'd0, tick};
        state_d    = state_q;
        width_d    = width_q;
        trig_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig_rise)
                    state_d = S_TRIG;
            end
            S_TRIG: begin
                if (trig_fall) begin
                    if (us_eff >= TRIG_MIN) begin
                        state_d = S_BURST;
                        width_d = width_calc;
                    end else begin
                        state_d    = S_IDLE;
                        trig_err_d = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (tick && us_q == BURST_LAST)
                    state_d = S_ECHO;
            end
            S_ECHO: begin
                if (tick && us_q == width_q - 24'd1)
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (tick && us_q == HOLD_LAST)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Timebase restarts on every state change so durations are whole microseconds.
        if (state_d != state_q) begin
            presc_d = '0;
            us_d    = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            us_d    = (tick && us_q != '1) ? us_q + 24'd1 : us_q;
        end

        echo_d = (state_d == S_ECHO);
        busy_d = (state_q != S_IDLE);
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign trig_err = trig_err_q;

endmodule

// File: doc/hc_sr04_emulator.md
# hc_sr04_emulator

Cycle-accurate model of the HC-SR04 ultrasonic sensor, the responder side of the trigger/echo protocol driven by the range-measurement FSM. It accepts a trigger pulse, waits out the acoustic burst time, then drives an echo pulse whose width encodes a programmed distance in centimetres. It is used as synthesizable loopback hardware on the board and as the sensor model in the measurement testbenches.

## Interface
- RANGE_WIDTH, 16, width of `range_cm` input
- DELAY_CLK_1US, 50, clk cycles per microsecond
- DELAY_1US_1SM, 58, echo microseconds per centimetre
- DELAY_TRIGGER_US, 10, minimum accepted trigger high time, us
- DELAY_BURST_US, 450, trigger-fall to echo-rise delay, us
- DELAY_TIMEOUT_US, 38000, echo width for out-of-range target, us
- MAX_RANGE_CM, 400, largest valid distance, cm
- DELAY_HOLDOFF_US, 10000, dead time after echo fall, us
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- trigger  input  1  trigger from controller, asynchronous to clk
- range_cm  input  RANGE_WIDTH  simulated target distance, cm
- echo  output  1  echo pulse to controller, registered
- busy  output  1  high whenever FSM is not IDLE, registered
- trig_err  output  1  one-cycle pulse: trigger shorter than DELAY_TRIGGER_US

## Operation
- `trigger` passes a 2-FF synchronizer plus one history register; rise/fall detected from synchronized value vs history.
- Internal us prescaler: counts 0..DELAY_CLK_1US-1, emits tick on terminal count; restarts at 0 on every FSM state change, so every state duration is an exact multiple of DELAY_CLK_1US clocks.
- us counter: 24 bits, cleared on state entry, incremented per tick, saturates at all-ones.
- States: IDLE -> TRIG on synced rise. TRIG: counts high time; on synced fall, count >= DELAY_TRIGGER_US -> BURST and latch `range_cm`, else pulse `trig_err`, -> IDLE. BURST: DELAY_BURST_US us -> ECHO. ECHO: `echo`=1 for width W us -> HOLD. HOLD: DELAY_HOLDOFF_US us -> IDLE.
- W = latched_range * DELAY_1US_1SM, computed once at BURST entry into a 24-bit register.
- Latched range 0 or > MAX_RANGE_CM: out-of-range, handling per Configuration.
- Trigger edges in BURST, ECHO, HOLD ignored. Entering IDLE with trigger already high: no measurement until a fresh rise.
- `range_cm` changes after latch have no effect on the current echo.

## Timing
- Reset (async): `echo`=0, `busy`=0, `trig_err`=0, FSM IDLE, prescaler and counters 0, synchronizer 0. Reset mid-echo drops `echo` immediately.
- Pin-to-FSM latency: 3 clk (2 sync + edge register); FSM state changes on the following edge.
- TRIG threshold: a pulse of exactly DELAY_TRIGGER_US*DELAY_CLK_1US clocks is accepted; one clock fewer (after sync) may be rejected, 2 ticks fewer always rejected.
- `echo` rises exactly DELAY_BURST_US*DELAY_CLK_1US clocks after BURST entry; stays high exactly W*DELAY_CLK_1US clocks.
- `busy` rises the cycle after TRIG entry, falls the cycle after IDLE entry.
- `trig_err` high exactly 1 clk, coincident with TRIG->IDLE transition.

## Configuration
- HC_SR04_EMU_TIMEOUT_EN defined: out-of-range (0 or > MAX_RANGE_CM) gives W = DELAY_TIMEOUT_US, mimicking the real sensor no-echo timeout.
- Undefined: out-of-range is clamped; 0 -> 1 cm, > MAX_RANGE_CM -> MAX_RANGE_CM; W = clamped*DELAY_1US_1SM.

## Test plan
- range_cm=100, trigger high 500 clk -> echo rises 22500 clk after BURST entry, high 290000 clk, busy high through HOLD, trig_err never.
- Trigger high 400 clk (8 us) -> trig_err one-cycle pulse, echo stays 0, busy back to 0, FSM IDLE.
- range_cm=500 with HC_SR04_EMU_TIMEOUT_EN -> echo high 1900000 clk; without macro -> echo high 1160000 clk (400 cm).
- Second trigger during ECHO and HOLD, range_cm changed 100->20 mid-echo -> ignored, echo width stays 290000 clk.
- rst_n low mid-ECHO -> echo and busy 0 immediately; after release, 10 us trigger with range_cm=1 -> echo 2900 clk.
- Trigger held high across HOLD->IDLE -> no new measurement until trigger falls and rises again.
